// File: rtl/stream_minmax.sv
// rtl/stream_minmax.sv - streaming frame min/max reducer with index reporting
// Optional build macro: STREAM_MINMAX_SIGNED_EN (two's-complement compare)
module stream_minmax #(
   parameter int W  = 8,
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_min,
   output logic [W-1:0]  out_max,
   output logic [IW-1:0] out_min_idx,
   output logic [IW-1:0] out_max_idx
);

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] cnt;
   logic [W-1:0]  acc_min;
   logic [W-1:0]  acc_max;
   logic [IW-1:0] acc_min_idx;
   logic [IW-1:0] acc_max_idx;

   logic          in_xfer;
   logic          first;
   logic          last;
   logic          less;
   logic          greater;
   logic [W-1:0]  nxt_min;
   logic [W-1:0]  nxt_max;
   logic [IW-1:0] nxt_min_idx;
   logic [IW-1:0] nxt_max_idx;

   // Only the final sample of a frame stalls, and only while a result is still held
   assign in_ready = rst && !((cnt == LAST) && out_valid && !out_ready);
   assign in_xfer  = in_valid && in_ready;
   assign first    = (cnt == '0);
   assign last     = (cnt == LAST);

`ifdef STREAM_MINMAX_SIGNED_EN
   assign less    = $signed(in_data) < $signed(acc_min);
   assign greater = $signed(in_data) > $signed(acc_max);
`else
   assign less    = in_data < acc_min;
   assign greater = in_data > acc_max;
`endif

   // Running extremes including the current sample; strict compares keep the earliest index on ties
   always_comb begin
      nxt_min     = acc_min;
      nxt_max     = acc_max;
      nxt_min_idx = acc_min_idx;
      nxt_max_idx = acc_max_idx;
      if (first) begin
         nxt_min     = in_data;
         nxt_max     = in_data;
         nxt_min_idx = '0;
         nxt_max_idx = '0;
      end else begin
         if (less) begin
            nxt_min     = in_data;
            nxt_min_idx = cnt;
         end
         if (greater) begin
            nxt_max     = in_data;
            nxt_max_idx = cnt;
         end
      end
   end

   // Accumulate samples and hand completed frames to the output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt         <= '0;
         acc_min     <= '0;
         acc_max     <= '0;
         acc_min_idx <= '0;
         acc_max_idx <= '0;
         out_valid   <= 1'b0;
         out_min     <= '0;
         out_max     <= '0;
         out_min_idx <= '0;
         out_max_idx <= '0;
      end else begin
         if (in_xfer) begin
            acc_min     <= nxt_min;
            acc_max     <= nxt_max;
            acc_min_idx <= nxt_min_idx;
            acc_max_idx <= nxt_max_idx;
            cnt         <= last ? '0 : cnt + 1'b1;
         end
         if (in_xfer && last) begin
            out_min     <= nxt_min;
            out_max     <= nxt_max;
            out_min_idx <= nxt_min_idx;
            out_max_idx <= nxt_max_idx;
            out_valid   <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_minmax.sv
// tb/tb_stream_minmax.sv - scoreboard bench for stream_minmax (N=4 and N=16 instances)
module tb_stream_minmax;

   typedef struct {
      logic [7:0] mn;
      int         mni;
      logic [7:0] mx;
      int         mxi;
   } res_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       iv4 = 1'b0, or4 = 1'b1;
   logic [7:0] id4 = '0;
   logic       ir4, ov4;
   logic [7:0] mn4, mx4;
   logic [1:0] mni4, mxi4;

   logic       iv16 = 1'b0, or16 = 1'b1;
   logic [7:0] id16 = '0;
   logic       ir16, ov16;
   logic [7:0] mn16, mx16;
   logic [3:0] mni16, mxi16;

   res_t q4[$];
   res_t q16[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   int   b2b_on = 0;
   int   b2b_drops = 0;

   stream_minmax #(.W(8), .N(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
      .out_valid(ov4), .out_ready(or4), .out_min(mn4), .out_max(mx4),
      .out_min_idx(mni4), .out_max_idx(mxi4)
   );

   stream_minmax #(.W(8), .N(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
      .out_valid(ov16), .out_ready(or16), .out_min(mn16), .out_max(mx16),
      .out_min_idx(mni16), .out_max_idx(mxi16)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic res_t mk(input int mn, input int mni, input int mx, input int mxi);
      res_t r;
      r.mn = 8'(mn); r.mni = mni; r.mx = 8'(mx); r.mxi = mxi;
      return r;
   endfunction

   // Monitor: an output transfer happens on the next edge when valid and ready are both high here
   always @(negedge clk) begin
      res_t e;
      if (b2b_on != 0 && !ir4) b2b_drops++;
      if (ov4 && or4) begin
         if (q4.size() == 0) chk("n4_unexpected_result", 1, 0);
         else begin
            e = q4.pop_front();
            chk("n4_min", int'(mn4), int'(e.mn));
            chk("n4_min_idx", int'(mni4), e.mni);
            chk("n4_max", int'(mx4), int'(e.mx));
            chk("n4_max_idx", int'(mxi4), e.mxi);
         end
      end
      if (ov16 && or16) begin
         if (q16.size() == 0) chk("n16_unexpected_result", 1, 0);
         else begin
            e = q16.pop_front();
            chk("n16_min", int'(mn16), int'(e.mn));
            chk("n16_min_idx", int'(mni16), e.mni);
            chk("n16_max", int'(mx16), int'(e.mx));
            chk("n16_max_idx", int'(mxi16), e.mxi);
         end
      end
   end

   // Present one sample and hold it until accepted; in_valid stays high for back-to-back use
   task automatic send(input int which, input int d);
      int n;
      if (which == 0) begin iv4 = 1'b1; id4 = 8'(d); end
      else begin iv16 = 1'b1; id16 = 8'(d); end
      n = 0;
      @(negedge clk);
      while (((which == 0) ? ir4 : ir16) !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("send_timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      iv4 = 1'b0; iv16 = 1'b0;
   endtask

   int t0;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", int'(ov4), 0);
      chk("rst_in_ready", int'(ir4), 0);
      chk("rst_out_min", int'(mn4), 0);
      chk("rst_out_max_idx", int'(mxi4), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Basic frame with a tie on the maximum
      q4.push_back(mk(1, 2, 9, 1));
      send(0, 3); send(0, 9); send(0, 1); send(0, 9);
      idle();
      repeat (3) @(posedge clk); #1;

      // Signed versus unsigned interpretation
`ifdef STREAM_MINMAX_SIGNED_EN
      q4.push_back(mk(8'h80, 3, 8'h7F, 2));
`else
      q4.push_back(mk(8'h05, 0, 8'hFF, 1));
`endif
      send(0, 8'h05); send(0, 8'hFF); send(0, 8'h7F); send(0, 8'h80);
      idle();
      repeat (3) @(posedge clk); #1;

      // Backpressure: A held while B's last sample stalls
      or4 = 1'b0;
      q4.push_back(mk(10, 0, 40, 3));
      send(0, 10); send(0, 20); send(0, 30); send(0, 40);
      q4.push_back(mk(5, 1, 60, 2));
      send(0, 50); send(0, 5); send(0, 60);
      iv4 = 1'b1; id4 = 8'd5;
      @(negedge clk);
      chk("bp_in_ready_low", int'(ir4), 0);
      chk("bp_out_valid_held", int'(ov4), 1);
      chk("bp_a_min_held", int'(mn4), 10);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_still_stalled", int'(ir4), 0);
      chk("bp_a_max_held", int'(mx4), 40);
      @(posedge clk); #1;
      or4 = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_release", int'(ir4), 1);
      @(posedge clk); #1;
      or4 = 1'b0; idle();
      @(negedge clk);
      chk("bp_no_bubble", int'(ov4), 1);
      chk("bp_b_min", int'(mn4), 5);
      @(posedge clk); #1;
      or4 = 1'b1;
      repeat (3) @(posedge clk); #1;

      // Back-to-back frames: 12 samples in 12 cycles
      q4.push_back(mk(1, 0, 4, 3));
      q4.push_back(mk(1, 3, 4, 0));
      q4.push_back(mk(8, 0, 8, 0));
      b2b_on = 1;
      t0 = cycle;
      send(0, 1); send(0, 2); send(0, 3); send(0, 4);
      send(0, 4); send(0, 3); send(0, 2); send(0, 1);
      send(0, 8); send(0, 8); send(0, 8); send(0, 8);
      chk("b2b_cycles", cycle - t0, 12);
      b2b_on = 0;
      idle();
      chk("b2b_ready_drops", b2b_drops, 0);
      repeat (3) @(posedge clk); #1;

      // Reset mid-frame while a result is held
      or4 = 1'b0;
      send(0, 1); send(0, 2); send(0, 3); send(0, 4);
      send(0, 9); send(0, 9);
      idle();
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_out_valid", int'(ov4), 0);
      chk("mid_rst_in_ready", int'(ir4), 0);
      chk("mid_rst_out_min", int'(mn4), 0);
      chk("mid_rst_out_max", int'(mx4), 0);
      chk("mid_rst_out_min_idx", int'(mni4), 0);
      @(posedge clk); #1;
      rst = 1'b1; or4 = 1'b1;
      q4.push_back(mk(7, 0, 7, 0));
      send(0, 7); send(0, 7); send(0, 7); send(0, 7);
      idle();
      repeat (3) @(posedge clk); #1;

      // N=16: constant zero frame, then a ramp
      q16.push_back(mk(0, 0, 0, 0));
      for (int i = 0; i < 16; i++) send(1, 0);
      q16.push_back(mk(0, 0, 15, 15));
      for (int i = 0; i < 16; i++) send(1, i);
      idle();
      repeat (5) @(posedge clk); #1;

      chk("n4_results_drained", q4.size(), 0);
      chk("n16_results_drained", q16.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_minmax.md
# stream_minmax

Parametrised streaming min/max reducer. It accepts a valid/ready stream of W-bit samples, splits it into frames of N samples, and emits one result per frame through a registered valid/ready output. Each result carries the frame minimum, the frame maximum and the in-frame index of each. It sits after sample sources in the lab datapath and extends the earlier two-input min/max block to arbitrary frame length, backpressure and index reporting.

## Interface
- W, default 8: sample width in bits, ≥1.
- N, default 16: samples per frame, ≥2.
- IW, default $clog2(N): index width. Derived; not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  W  input sample.
- out_valid  out  1  result registers hold an unconsumed frame result.
- out_ready  in  1  downstream accepts the result.
- out_min  out  W  frame minimum.
- out_max  out  W  frame maximum.
- out_min_idx  out  IW  index (0..N-1) of the minimum within the frame.
- out_max_idx  out  IW  index (0..N-1) of the maximum within the frame.

## Operation
- An input transfer is in_valid && in_ready on a clock edge. An output transfer is out_valid && out_ready on a clock edge.
- Internal state:
  - cnt (IW bits): position of the next sample in the current frame.
  - acc_min, acc_max, acc_min_idx, acc_max_idx.
  - A separate output register set.
- First sample of a frame (cnt==0): acc_min = acc_max = in_data; both indices = 0.
- Later samples:
  - acc_min is replaced only if in_data < acc_min (strict).
  - acc_max is replaced only if in_data > acc_max (strict).
  - The replaced value's index is set to cnt.
  - Ties keep the earliest index.
- Comparison is unsigned by default; see Configuration.
- cnt increments on each input transfer and wraps to 0 after N-1.
- Last sample (cnt==N-1) transfer: the output registers load the final min/max/indices, including the last sample's own comparison, and out_valid is set.
- Output register stability: contents and out_valid are unchanged while out_valid=1 and out_ready=0.
- Output transfer without a load in the same cycle: out_valid clears to 0. The data registers keep their values.
- Output transfer and load in the same cycle: the new result loads and out_valid stays 1. There is no bubble.
- Backpressure:
  - in_ready = rst && !(cnt==N-1 && out_valid && !out_ready).
  - Accumulation of the next frame continues while a result waits.
  - Only the final sample of a frame stalls, and only while an unconsumed result is held.
- Reset, at any time, including mid-frame or while out_valid=1:
  - cnt=0 and out_valid=0.
  - All accumulators, out_min, out_max, out_min_idx and out_max_idx = 0.
  - The partial frame is discarded.
  - in_ready=0 during reset.

## Timing
- Latency: the result is visible on the edge that accepts the last sample, i.e. out_valid is high from the following cycle.
- Throughput: 1 sample/cycle sustained while out_ready=1. N back-to-back frames need N·N cycles with no idle cycles.
- in_ready is combinational from cnt, out_valid and out_ready. There is no combinational path from in_valid or in_data to any output.
- All outputs except in_ready are registered.
- First accepting edge after reset release: the edge where rst=1 is sampled with in_valid=1.

## Configuration
- STREAM_MINMAX_SIGNED_EN:
  - When defined: in_data, acc_* and the comparisons are treated as two's-complement signed W-bit values.
  - When undefined: all comparisons are unsigned.
- Ports, widths, indices and timing are identical in both builds.

## Test plan
- Basic frame (W=8, N=4, out_ready=1): samples 3,9,1,9 -> one out_valid pulse with out_min=1, out_min_idx=2, out_max=9, out_max_idx=1 (tie keeps idx 1).
- Signed build (STREAM_MINMAX_SIGNED_EN, W=8, N=4): samples 0x05,0xFF,0x7F,0x80 -> out_min=0x80 idx 3, out_max=0x7F idx 2. Unsigned build with the same samples -> out_min=0x05 idx 0, out_max=0xFF idx 1.
- Backpressure (N=4): frame A completes and out_ready is held 0. Then:
  - The first 3 samples of frame B are accepted.
  - in_ready=0 on the 4th; A is held stable.
  - Raise out_ready for one cycle: A is consumed and B's 4th sample is accepted on the same edge.
  - out_valid stays 1 and B's result appears on the next cycle.
- Back-to-back (N=4, out_ready=1, in_valid=1 continuously): 3 frames in 12 cycles; in_ready never drops; out_valid is high one cycle per frame.
- Reset mid-operation: assert rst=0 after 2 samples of a frame while out_valid=1 -> next cycle all outputs 0 and out_valid=0. After release, 4 new samples 7,7,7,7 -> min=max=7, both indices 0.
- Constant/extreme data (W=8, N=16): all samples 0x00 -> min=max=0, indices 0. Ramp 0..15 -> min 0 idx 0, max 15 idx 15.
